// File: rtl/ad7124_pkg.sv
// ad7124_pkg: AD7124 comms bytes, STATUS field positions and read-sequencer state encoding.
package ad7124_pkg;
    localparam logic [7:0] COMMS_STATUS_RD = 8'h40;
    localparam logic [7:0] COMMS_DATA_RD   = 8'h42;
    localparam int RDY_N  = 7;
    localparam int CH_MSB = 3;
    localparam int CH_LSB = 0;
    localparam int DATA_W = 24;
    localparam int CHAN_W = CH_MSB - CH_LSB + 1;
    typedef enum logic [2:0] {
        IDLE,
        ISSUE_STAT,
        WAIT_STAT,
        GAP,
        ISSUE_DATA,
        WAIT_DATA,
        PUSH
    } seq_state_t;
endpackage

// File: rtl/ad7124_sample_hold.sv
// ad7124_sample_hold: one-entry valid/ready register; a load that finds the entry full and not accepted is dropped and flagged.
module ad7124_sample_hold
    import ad7124_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CHAN_W-1:0] i_chan,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CHAN_W-1:0] o_chan,
    output logic              o_valid,
    output logic              o_overflow
);
    logic [DATA_W-1:0] r_data;
    logic [CHAN_W-1:0] r_chan;
    logic              r_valid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else if (i_load && (!r_valid || i_ready)) begin
            r_data  <= i_data;
            r_chan  <= i_chan;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end
    assign o_data     = r_data;
    assign o_chan     = r_chan;
    assign o_valid    = r_valid;
    assign o_overflow = i_load && r_valid && !i_ready;
endmodule

// File: rtl/ad7124_read_sequencer.sv
// ad7124_read_sequencer: polls AD7124 STATUS until RDY_n is low, then reads DATA and
// presents the channel-tagged sample on a valid/ready output with sticky timeout/overflow flags.
module ad7124_read_sequencer
    import ad7124_pkg::*;
#(
    parameter logic [7:0] STATUS_CMD = COMMS_STATUS_RD,
    parameter logic [7:0] DATA_CMD   = COMMS_DATA_RD,
    parameter int         POLL_GAP   = 64,
    parameter int         TIMEOUT    = 4096,
    parameter int         CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [7:0]  cmd_data,
    output logic        cmd_valid,
    input  logic [23:0] rsp_data,
    input  logic        rsp_valid,
    output logic [23:0] m_data,
    output logic [3:0]  m_chan,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic        overflow,
    input  logic        err_clr
);
    seq_state_t        r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_cmd;
    logic [CHAN_W-1:0] r_chan;
    logic [DATA_W-1:0] r_sample;
    logic              r_tmo_err, r_ovf;
    logic              w_wait, w_tmo, w_gap_done, w_not_rdy, w_ovf;

    assign w_wait     = (r_state == WAIT_STAT) || (r_state == WAIT_DATA);
    assign w_tmo      = w_wait && !rsp_valid && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_gap_done = r_cnt == CNT_W'(POLL_GAP - 1);
    assign w_not_rdy  = rsp_data[16+RDY_N];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = enable ? ISSUE_STAT : IDLE;
            ISSUE_STAT: w_next = WAIT_STAT;
            WAIT_STAT:  w_next = rsp_valid ? (w_not_rdy ? GAP : ISSUE_DATA) : (w_tmo ? GAP : WAIT_STAT);
            GAP:        w_next = w_gap_done ? (enable ? ISSUE_STAT : IDLE) : GAP;
            ISSUE_DATA: w_next = WAIT_DATA;
            WAIT_DATA:  w_next = rsp_valid ? PUSH : (w_tmo ? GAP : WAIT_DATA);
            PUSH:       w_next = enable ? ISSUE_STAT : IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // One counter serves both the poll gap and the response timeout; it restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_chan    <= '0;
            r_sample  <= '0;
            r_tmo_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_cmd     <= (w_next == ISSUE_STAT) ? STATUS_CMD : (w_next == ISSUE_DATA) ? DATA_CMD : r_cmd;
            if (r_state == WAIT_STAT && rsp_valid && !w_not_rdy)
                r_chan <= rsp_data[16+CH_MSB:16+CH_LSB];
            if (r_state == WAIT_DATA && rsp_valid)
                r_sample <= rsp_data;
            r_tmo_err <= w_tmo || (r_tmo_err && !err_clr);
            r_ovf     <= w_ovf || (r_ovf && !err_clr);
        end
    end

    ad7124_sample_hold u_hold (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == PUSH),
        .i_data     (r_sample),
        .i_chan     (r_chan),
        .i_ready    (m_ready),
        .o_data     (m_data),
        .o_chan     (m_chan),
        .o_valid    (m_valid),
        .o_overflow (w_ovf)
    );

    assign cmd_data    = r_cmd;
    assign cmd_valid   = (r_state == ISSUE_STAT) || (r_state == ISSUE_DATA);
    assign busy        = r_state != IDLE;
    assign timeout_err = r_tmo_err;
    assign overflow    = r_ovf;
endmodule

// File: tb/tb_ad7124_read_sequencer.sv
// tb_ad7124_read_sequencer: directed bench acting as the SPI master; drives and samples on the falling edge.
module tb_ad7124_read_sequencer;
    localparam int POLL_GAP = 64;
    localparam int TIMEOUT  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic [23:0] rsp_data = '0;
    logic        rsp_valid = 1'b0;
    logic [23:0] m_data;
    logic [3:0]  m_chan;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic        overflow;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ad7124_read_sequencer #(
        .POLL_GAP (POLL_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .m_data      (m_data),
        .m_chan      (m_chan),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overflow    (overflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Returns at the falling edge where cmd_valid is seen, with the cycle number of that pulse.
    task automatic wait_cmd(input string tag, input logic [7:0] exp, output int at);
        at = -1;
        for (int i = 0; i < 6000; i++) begin
            if (cmd_valid) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        if (at < 0) check({tag, "_no_cmd"}, 32'd0, 32'd1);
        else check(tag, {24'd0, cmd_data}, {24'd0, exp});
    endtask

    task automatic respond(input logic [23:0] d);
        rsp_data  = d;
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = 24'hEEEEEE;
    endtask

    initial begin
        int t, r, c, n;
        repeat (3) @(negedge clk);
        check("rst_cmd_data", {24'd0, cmd_data}, 32'd0);
        check("rst_outs", {26'd0, cmd_valid, m_valid, busy, timeout_err, overflow, 1'b0}, 32'd0);
        check("rst_m", {4'd0, m_chan, m_data}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ready on first poll
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_cmd("t1_stat", 8'h40, t);
        repeat (3) @(negedge clk);
        respond(24'h05ABCD);
        wait_cmd("t1_data", 8'h42, t);
        repeat (2) @(negedge clk);
        respond(24'h123456);
        check("t1_valid_lat1", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("t1_valid_lat2", {31'd0, m_valid}, 32'd1);
        check("t1_data", {8'd0, m_data}, 32'h123456);
        check("t1_chan", {28'd0, m_chan}, 32'd5);

        // not ready three times, gap of POLL_GAP idle cycles each
        wait_cmd("t2_stat0", 8'h40, t);
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(negedge clk);
            r = cyc;
            respond(24'h801234);
            wait_cmd("t2_stat", 8'h40, c);
            check("t2_gap", 32'(c - r - 1), 32'(POLL_GAP));
        end
        repeat (2) @(negedge clk);
        respond(24'h020000);
        wait_cmd("t2_data", 8'h42, t);
        repeat (2) @(negedge clk);
        respond(24'h0000AA);
        @(negedge clk);
        check("t2_chan", {28'd0, m_chan}, 32'd2);
        check("t2_m", {8'd0, m_data}, 32'h0000AA);

        // timeout on an unanswered STATUS read
        wait_cmd("t3_stat", 8'h40, t);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("t3_tmo_early", {31'd0, timeout_err}, 32'd0);
        repeat (2) @(negedge clk);
        check("t3_tmo_set", {31'd0, timeout_err}, 32'd1);
        wait_cmd("t3_restat", 8'h40, c);
        check("t3_gap", 32'(c - (t + TIMEOUT) - 1), 32'(POLL_GAP));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3_tmo_clr", {31'd0, timeout_err}, 32'd0);

        // backpressure: second sample dropped, overflow flagged
        m_ready = 1'b0;
        respond(24'h010000);
        wait_cmd("t4_data1", 8'h42, t);
        repeat (2) @(negedge clk);
        respond(24'h000001);
        wait_cmd("t4_stat", 8'h40, t);
        check("t4_ovf_none", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        respond(24'h010000);
        wait_cmd("t4_data2", 8'h42, t);
        repeat (2) @(negedge clk);
        respond(24'h000002);
        wait_cmd("t4_stat2", 8'h40, t);
        check("t4_held", {8'd0, m_data}, 32'h000001);
        check("t4_ovf", {30'd0, m_valid, overflow}, 32'd3);
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("t4_consumed", {31'd0, m_valid}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_ovf_clr", {31'd0, overflow}, 32'd0);

        // accept and load in the same cycle
        respond(24'h030000);
        wait_cmd("t5_data1", 8'h42, t);
        repeat (2) @(negedge clk);
        respond(24'h000003);
        wait_cmd("t5_stat", 8'h40, t);
        check("t5_first", {7'd0, m_valid, m_data}, 32'h01000003);
        repeat (2) @(negedge clk);
        respond(24'h030000);
        wait_cmd("t5_data2", 8'h42, t);
        repeat (2) @(negedge clk);
        respond(24'h000004);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("t5_loaded", {7'd0, m_valid, m_data}, 32'h01000004);
        check("t5_no_ovf", {31'd0, overflow}, 32'd0);

        // enable dropped during WAIT_DATA
        wait_cmd("t6_stat", 8'h40, t);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        respond(24'h060000);
        wait_cmd("t6_data", 8'h42, t);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        respond(24'h000777);
        check("t6_busy_push", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t6_sample", {3'd0, m_valid, m_chan, m_data}, {3'd0, 1'b1, 4'd6, 24'h000777});
        check("t6_idle", {31'd0, busy}, 32'd0);
        n = 0;
        repeat (200) begin
            if (cmd_valid) n++;
            @(negedge clk);
        end
        check("t6_no_cmd", 32'(n), 32'd0);

        // asynchronous reset during WAIT_STAT
        enable = 1'b1;
        wait_cmd("t7_stat", 8'h40, t);
        repeat (2) @(negedge clk);
        check("t7_pre", {30'd0, busy, m_valid}, 32'd3);
        #2 rst = 1'b0;
        #1;
        check("t7_rst_outs", {26'd0, cmd_valid, m_valid, busy, timeout_err, overflow, 1'b0}, 32'd0);
        check("t7_rst_m", {4'd0, m_chan, m_data}, 32'd0);
        check("t7_rst_cmd", {24'd0, cmd_data}, 32'd0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/ad7124_read_sequencer.md
Name: ad7124_read_sequencer

Overview:
- Upstream controller for the AD7124 SPI transmit/receive master. It sets the command byte and pulse (data_i/data_ie) and consumes the 24-bit read word and its strobe (data_o/wr_en).
- Runs an autonomous poll loop: read STATUS, test RDY_n, then read DATA when a conversion is ready.
- Each sample is tagged with the active channel taken from STATUS and presented on a valid/ready output stage. Timeout and overflow are reported as sticky flags.

Parameters:
- STATUS_CMD, 8'h40, comms byte for a STATUS register read.
- DATA_CMD, 8'h42, comms byte for a DATA register read.
- POLL_GAP, 64, idle clk cycles between a not-ready STATUS read and the next STATUS read.
- TIMEOUT, 4096, clk cycles from cmd_valid to rsp_valid before the transaction is abandoned.
- CNT_W, 16, width of the gap/timeout counter; must satisfy 2^CNT_W > max(POLL_GAP, TIMEOUT).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- enable, input, 1, level; run the poll loop while high.
- cmd_data, output, 8, command byte to the SPI master data_i.
- cmd_valid, output, 1, one-cycle pulse to the SPI master data_ie.
- rsp_data, input, 24, read word from the SPI master data_o.
- rsp_valid, input, 1, one-cycle strobe from the SPI master wr_en.
- m_data, output, 24, sample value.
- m_chan, output, 4, channel tag from STATUS[3:0].
- m_valid, output, 1, sample valid.
- m_ready, input, 1, downstream accept.
- busy, output, 1, high when the state is not IDLE.
- timeout_err, output, 1, sticky.
- overflow, output, 1, sticky.
- err_clr, input, 1, clears both sticky flags.

Behaviour:
- Reset values: cmd_data=0, cmd_valid=0, m_data=0, m_chan=0, m_valid=0, busy=0, timeout_err=0, overflow=0, state=IDLE.
- FSM states: IDLE, ISSUE_STAT, WAIT_STAT, GAP, ISSUE_DATA, WAIT_DATA, PUSH.
- IDLE:
  - If enable, go to ISSUE_STAT next cycle.
- ISSUE_STAT (1 cycle):
  - cmd_data=STATUS_CMD, cmd_valid=1, counter cleared; go to WAIT_STAT.
- WAIT_STAT:
  - On rsp_valid, latch status = rsp_data[23:16]; rsp_data[15:0] is ignored.
  - If status[7]==0 (ready): store chan=status[3:0] and go to ISSUE_DATA.
  - Otherwise go to GAP.
  - If the counter reaches TIMEOUT-1 without rsp_valid: set timeout_err and go to GAP.
- GAP:
  - Count POLL_GAP cycles.
  - Then go to ISSUE_STAT if enable, else IDLE.
- ISSUE_DATA (1 cycle):
  - cmd_data=DATA_CMD, cmd_valid=1, counter cleared; go to WAIT_DATA.
- WAIT_DATA:
  - On rsp_valid, latch rsp_data and go to PUSH.
  - Same timeout rule as WAIT_STAT; on timeout no sample is produced.
- PUSH (1 cycle):
  - Write {chan, data} into the output register.
  - Go directly to ISSUE_STAT (no gap) if enable, else IDLE.
- Single outstanding command:
  - cmd_valid is never asserted outside the ISSUE states, so at most one command is outstanding.
  - cmd_data holds its last value between pulses.
- Output register:
  - m_valid clears on m_valid && m_ready.
  - On PUSH while m_valid && !m_ready: the new sample is dropped, the held sample is unchanged, and overflow is set.
  - On PUSH in the same cycle as m_valid && m_ready: the new sample is loaded, m_valid stays 1, and no overflow is flagged.
- Sticky flags:
  - err_clr clears timeout_err and overflow.
  - If a set event and err_clr occur in the same cycle, set wins.
- enable deasserted mid-transaction:
  - An outstanding WAIT completes (response or timeout), PUSH executes if reached, then the FSM returns to IDLE.
  - No new command is issued.
- rsp_valid outside WAIT states is ignored.
- Reset mid-operation aborts everything.
  - The SPI master shares rst, so no stale response can arrive after reset.
- Latency: one rsp_valid of the DATA read to m_valid = 2 clk cycles (WAIT_DATA capture, PUSH register).

Decomposition:
- ad7124_pkg holds:
  - the comms constants (STATUS_CMD 8'h40, DATA_CMD 8'h42);
  - the STATUS bit positions (RDY_N=7, CH_MSB=3, CH_LSB=0);
  - the FSM state encoding.
- One sub-module: ad7124_sample_hold.
  - 1-entry valid/ready holding register with an overflow-detect output.
  - Instantiated once for m_data/m_chan/m_valid.

Test Plan:
- Ready on first poll: enable=1; SPI model answers STATUS rsp_data=24'h05xxxx, then DATA 24'h123456 with m_ready=1 -> cmd_data sequence 40,42; m_data=24'h123456, m_chan=5, m_valid 2 cycles after the DATA rsp_valid.
- Not ready: STATUS 24'h80xxxx three times, then 24'h02xxxx -> three gaps of exactly POLL_GAP cycles between STATUS pulses; then DATA 42 issued; m_chan=2.
- Timeout: the model never asserts rsp_valid after a 40 command -> timeout_err=1 at TIMEOUT cycles after cmd_valid; next STATUS issued after POLL_GAP; err_clr returns timeout_err to 0.
- Backpressure: m_ready=0 while two samples 24'h000001 and 24'h000002 are produced -> m_data stays 24'h000001 and overflow=1; raising m_ready consumes exactly one sample.
- Simultaneous accept/load: m_ready asserted in the same cycle as PUSH with an existing sample -> new sample loaded, m_valid stays 1, overflow=0.
- enable drop and reset: enable falls during WAIT_DATA -> sample still pushed, busy falls, no further cmd_valid. rst asserted during WAIT_STAT -> all outputs return to reset values immediately.
